// File: rtl/rob_commit_unit_if.sv
// Allocation, writeback and commit signal bundle of the reorder buffer.
// The master side is the core (rename/execute/consumers); the slave side is the ROB.
interface rob_commit_unit_if #(
    parameter int ROB_IDX_W = 4,
    parameter int PHY_REG_W = 6,
    parameter int VAL_W     = 32,
    parameter int ADDR_W    = 32
);
    logic                 alloc_valid;
    logic                 alloc_ready;
    logic                 alloc_has_dst;
    logic [PHY_REG_W-1:0] alloc_phy_dst;
    logic [ADDR_W-1:0]    alloc_pc;
    logic [ROB_IDX_W-1:0] alloc_tag;
    logic                 wb_valid;
    logic [ROB_IDX_W-1:0] wb_tag;
    logic [VAL_W-1:0]     wb_value;
    logic                 flush;
    logic                 commit_valid;
    logic                 commit_with_write;
    logic [PHY_REG_W-1:0] commited_wr_register;
    logic [VAL_W-1:0]     commit_wr_val;
    logic [ADDR_W-1:0]    commit_pc;
    logic [ROB_IDX_W:0]   rob_count;
    logic                 rob_empty;

    modport master (
        output alloc_valid, alloc_has_dst, alloc_phy_dst, alloc_pc,
        output wb_valid, wb_tag, wb_value, flush,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_with_write, commited_wr_register, commit_wr_val, commit_pc,
        input  rob_count, rob_empty
    );

    modport slave (
        input  alloc_valid, alloc_has_dst, alloc_phy_dst, alloc_pc,
        input  wb_valid, wb_tag, wb_value, flush,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_with_write, commited_wr_register, commit_wr_val, commit_pc,
        output rob_count, rob_empty
    );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order commit stage: allocates at tail, completes out of order on writeback,
// retires one done entry per cycle from head onto registered commit outputs.
module rob_commit_unit #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_IDX_W = 4,
    parameter int PHY_REG_W = 6,
    parameter int VAL_W     = 32,
    parameter int ADDR_W    = 32
) (
    input logic              clk,
    input logic              reset,
    rob_commit_unit_if.slave robIf
);
    localparam logic [ROB_IDX_W:0]   DEPTH_CNT = ROB_DEPTH[ROB_IDX_W:0];
    localparam logic [ROB_IDX_W:0]   CNT_ONE   = 1;
    localparam logic [ROB_IDX_W-1:0] PTR_ONE   = 1;

    logic [ROB_IDX_W-1:0] headPtr;
    logic [ROB_IDX_W-1:0] tailPtr;
    logic [ROB_IDX_W:0]   robCount;
    logic [ROB_DEPTH-1:0] entryValid;
    logic [ROB_DEPTH-1:0] entryDone;
    logic [ROB_DEPTH-1:0] entryHasDst;
    logic [PHY_REG_W-1:0] entryPhyDst [ROB_DEPTH];
    logic [ADDR_W-1:0]    entryPc     [ROB_DEPTH];
    logic [VAL_W-1:0]     entryValue  [ROB_DEPTH];

    logic allocFire;
    logic wbFire;
    logic commitFire;

    assign robIf.alloc_ready = (robCount < DEPTH_CNT);
    assign robIf.alloc_tag   = tailPtr;
    assign robIf.rob_count   = robCount;
    assign robIf.rob_empty   = (robCount == '0);

    assign allocFire  = robIf.alloc_valid && robIf.alloc_ready;
    assign wbFire     = robIf.wb_valid && entryValid[robIf.wb_tag] && !entryDone[robIf.wb_tag];
    assign commitFire = entryValid[headPtr] && entryDone[headPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr                    <= '0;
            tailPtr                    <= '0;
            robCount                   <= '0;
            entryValid                 <= '0;
            entryDone                  <= '0;
            robIf.commit_valid         <= 1'b0;
            robIf.commit_with_write    <= 1'b0;
            robIf.commited_wr_register <= '0;
            robIf.commit_wr_val        <= '0;
            robIf.commit_pc            <= '0;
        end else if (robIf.flush) begin
            headPtr                 <= '0;
            tailPtr                 <= '0;
            robCount                <= '0;
            entryValid              <= '0;
            entryDone               <= '0;
            robIf.commit_valid      <= 1'b0;
            robIf.commit_with_write <= 1'b0;
        end else begin
            if (allocFire) begin
                entryValid[tailPtr] <= 1'b1;
                entryDone[tailPtr]  <= 1'b0;
                tailPtr             <= tailPtr + PTR_ONE;
            end
            if (wbFire) begin
                entryDone[robIf.wb_tag] <= 1'b1;
            end
            robIf.commit_valid      <= commitFire;
            robIf.commit_with_write <= commitFire && entryHasDst[headPtr];
            // Data outputs hold their last retired values when nothing commits.
            if (commitFire) begin
                entryValid[headPtr]        <= 1'b0;
                headPtr                    <= headPtr + PTR_ONE;
                robIf.commited_wr_register <= entryPhyDst[headPtr];
                robIf.commit_wr_val        <= entryValue[headPtr];
                robIf.commit_pc            <= entryPc[headPtr];
            end
            if (allocFire && !commitFire) begin
                robCount <= robCount + CNT_ONE;
            end else if (!allocFire && commitFire) begin
                robCount <= robCount - CNT_ONE;
            end
        end
    end

    // Payload needs no reset: it is only observed through entries marked valid and done.
    always_ff @(posedge clk) begin
        if (allocFire && !robIf.flush) begin
            entryHasDst[tailPtr] <= robIf.alloc_has_dst;
            entryPhyDst[tailPtr] <= robIf.alloc_phy_dst;
            entryPc[tailPtr]     <= robIf.alloc_pc;
        end
        if (wbFire && !robIf.flush) begin
            entryValue[robIf.wb_tag] <= robIf.wb_value;
        end
    end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- In-order commit stage (reorder buffer) for the out-of-order core.
- Allocates one entry per cycle in program order at rename/dispatch.
- Marks entries done on execution writeback, possibly out of order, and retires one entry per cycle in program order.
- On retire, drives the commit interface consumed by the decode/rename unit (free-list release) and the physical register file (commit write).

Parameters:
ROB_DEPTH, 16, number of entries; power of two, at least 4
ROB_IDX_W, 4, log2(ROB_DEPTH); width of tags and head/tail pointers
PHY_REG_W, 6, physical register number width (matches `PHYSICAL_REG_NUM_WIDTH)
VAL_W, 32, register value width (matches `REG_VAL_WIDTH)
ADDR_W, 32, instruction address width (matches `INST_ADDR_WIDTH)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
alloc_valid  in  1  rename presents an instruction
alloc_ready  out  1  entry available; combinational, equals rob_count < ROB_DEPTH
alloc_has_dst  in  1  instruction writes a destination register
alloc_phy_dst  in  PHY_REG_W  destination physical register
alloc_pc  in  ADDR_W  instruction PC
alloc_tag  out  ROB_IDX_W  tag assigned on allocation; combinational, equals tail
wb_valid  in  1  execution result available
wb_tag  in  ROB_IDX_W  entry being completed
wb_value  in  VAL_W  result value
flush  in  1  synchronous squash of all entries
commit_valid  out  1  registered; one retire this cycle
commit_with_write  out  1  registered; retired entry had a destination
commited_wr_register  out  PHY_REG_W  registered; retired destination physical register
commit_wr_val  out  VAL_W  registered; retired result
commit_pc  out  ADDR_W  registered; retired PC
rob_count  out  ROB_IDX_W+1  occupied entries
rob_empty  out  1  rob_count == 0

Behaviour:
- Reset (asynchronous, active-high):
  - head = tail = 0, rob_count = 0.
  - All entry valid and done bits cleared.
  - All commit_* outputs 0; rob_empty = 1; alloc_ready = 1.
- Entry contents: valid, done, has_dst, phy_dst, pc, value.
- Allocation:
  - Occurs at a rising edge when alloc_valid && alloc_ready.
  - Writes entry[tail]: valid = 1, done = 0, plus has_dst, phy_dst, pc.
  - tail increments modulo ROB_DEPTH; wrap is natural overflow of the ROB_IDX_W-bit pointer.
  - If alloc_valid is high while alloc_ready is low, nothing is written and the request is dropped; rename must hold the instruction.
- Writeback:
  - Occurs at a rising edge when wb_valid and entry[wb_tag].valid && !entry[wb_tag].done.
  - Sets done = 1 and value = wb_value.
  - Writeback to an invalid entry or an already-done entry is ignored.
  - Writeback to the tag being allocated in the same cycle is illegal and the bench must not drive it.
- Commit, evaluated at each rising edge:
  - If entry[head].valid && entry[head].done: commit_valid = 1, commit_with_write = has_dst, and commited_wr_register, commit_wr_val, commit_pc are loaded from entry[head]. Entry[head].valid is cleared and head increments modulo ROB_DEPTH.
  - Otherwise commit_valid = commit_with_write = 0, and the data outputs hold their previous values.
  - At most one commit per cycle, strictly in order; a younger done entry never retires before an older pending one.
- Latency:
  - A writeback sampled at edge E to the head entry gives commit_valid high after edge E+1.
  - Back-to-back done entries retire on consecutive cycles.
- rob_count:
  - next = count + (alloc fires) - (commit fires).
  - Allocation and commit in the same cycle leave the count unchanged.
  - alloc_ready uses the current count, so a full ROB does not accept an allocation even if a commit occurs in the same cycle.
- Flush (synchronous):
  - Highest priority; overrides allocation, writeback and commit in that cycle.
  - Next state: head = tail = 0, rob_count = 0, all valid/done bits cleared, commit_valid = commit_with_write = 0.
  - No entry retires in the flush cycle.
- Reset asserted mid-operation clears immediately, independent of clk.

Test Plan:
1. Assert reset, release, 3 idle cycles -> rob_empty = 1, alloc_ready = 1, alloc_tag = 0, commit_valid = 0 throughout.
2. Allocate 3 entries (pc 0x0/0x4/0x8, phy_dst 5/6/7, has_dst = 1), then writeback tags 2, 0, 1 with values 0x22/0x00/0x11 on consecutive cycles -> three consecutive commits in order: pc 0x0 reg 5 val 0x00, then pc 0x4 reg 6 val 0x11, then pc 0x8 reg 7 val 0x22. The first commit occurs one cycle after the tag 0 writeback edge.
3. Allocate 16 with no writeback -> rob_count = 16 and alloc_ready = 0. A 17th alloc_valid is dropped (tail unchanged). Writeback tag 0 -> one commit, after which alloc_ready = 1 and rob_count = 15.
4. Run more than 40 allocate/writeback/commit cycles -> tail and head wrap from 15 to 0, commits remain in program order, rob_count stays correct.
5. Allocate 5, writeback tag 0, assert flush in the cycle that tag 0 would commit -> no commit, rob_count = 0, next alloc_tag = 0.
6. Writeback to tag 9 while the ROB is empty -> ignored: no commit, rob_count = 0. Entry with has_dst = 0 -> commit_valid = 1, commit_with_write = 0.
